pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//   Program-counter generator for the MIPS-lite core: holds the PC register and computes next-PC
//   (sequential, beq, bne, j, jal, jr) with stall hold, a sticky misaligned-target trap and a
//   retired-instruction counter. Sits at the head of the fetch path and feeds IM and link logic.
//   Generalised successor of the combinational next-PC unit: parametrised width and reset vector,
//   plus an optional return-address stack (RAS) checker.
// PARAMETERS
//   WIDTH      32            PC/address width; legal 28..32
//   RESET_PC   32'h0000_3000 PC value after reset (truncated to WIDTH)
//   CNT_W      32            width of retired-instruction counter
//   RAS_DEPTH  4             RAS entries (power of 2, >=2); used only with PC_RAS_EN
// PORTS
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, active-low reset (0 = reset)
//   stall         in   1      1 = hold all state this cycle
//   pc_src        in   3      000 seq, 001 beq, 010 bne, 011 j, 100 jal, 101 jr, 11x = seq
//   zero          in   1      ALU zero flag for beq/bne
//   instr         in   32     current instruction (imm16 = [15:0], target26 = [25:0])
//   rs_data       in   WIDTH  register rs value (jr target)
//   rs_is_ra      in   1      1 = jr source register is $31 (RAS pop qualifier)
//   pc            out  WIDTH  current PC (registered)
//   pc_plus4      out  WIDTH  pc + 4 (combinational; jal link value)
//   addr_err      out  1      sticky: jr target had [1:0] != 0
//   inst_cnt      out  CNT_W  count of PC updates since reset
//   ras_mismatch  out  1      1-cycle registered pulse: RAS prediction != jr target
// BEHAVIOUR
//   - Reset (reset==0 at posedge): pc<=RESET_PC, addr_err<=0, inst_cnt<=0, RAS emptied,
//     ras_mismatch<=0. Reset overrides stall and any pending update.
//   - All arithmetic modulo 2^WIDTH. pc_plus4 = pc + 4.
//   - next_pc: seq -> pc_plus4; beq -> zero ? pc_plus4 + (sext(imm16)<<2) : pc_plus4;
//     bne -> !zero ? same target : pc_plus4; j/jal -> {pc_plus4[WIDTH-1:28], target26, 2'b00}
//     (for WIDTH==28: {target26,2'b00}); jr -> rs_data.
//   - Update enable upd = !stall && !addr_err. On upd: pc<=next_pc, inst_cnt<=inst_cnt+1 (wraps).
//   - Misaligned jr: if upd && pc_src==jr && rs_data[1:0]!=0 -> pc NOT updated, inst_cnt NOT
//     incremented, addr_err<=1. addr_err stays 1 (pc frozen) until reset.
//   - Branch/jump targets are word-aligned by construction; only jr can trap.
//   - stall==1: pc, inst_cnt, addr_err, RAS all hold; ras_mismatch<=0.
//   - Latency: next_pc visible on pc one cycle after the selecting inputs.
// CONFIGURATION
//   PC_RAS_EN defined: RAS of RAS_DEPTH entries plus occupancy count (0..RAS_DEPTH).
//     - jal with upd: push pc_plus4. Full: overwrite oldest (circular), count stays RAS_DEPTH.
//     - jr with upd && rs_is_ra && count>0: pop; ras_mismatch<=(popped != rs_data) next cycle.
//     - jr with count==0: no pop, ras_mismatch<=0. jr with !rs_is_ra: RAS untouched.
//     - Misaligned-jr trap cycle still pops/compares (RAS checks prediction, not legality).
//     - ras_mismatch is 0 in every cycle not following a qualifying pop.
//   PC_RAS_EN undefined: no RAS storage; ras_mismatch tied 0; rs_is_ra ignored.
// TESTING
//   1. reset=0 one edge, then reset=1, pc_src=000 x3 -> pc 0x3000,0x3004,0x3008,0x300C; inst_cnt=3.
//   2. pc=0x3010, beq imm16=0xFFFE zero=1 -> pc=0x300C; zero=0 -> 0x3014; bne zero=0 -> 0x300C.
//   3. pc=0x3000, j target26=0x0000C40 -> pc=0x00003100; stall=1 two cycles -> pc, inst_cnt unchanged.
//   4. jr rs_data=0x00003202 -> pc holds, addr_err=1; later seq cycles -> pc frozen; reset clears.
//   5. PC_RAS_EN: jal at pc=0x3000, then jr rs_is_ra rs_data=0x3004 -> no mismatch;
//      repeat with rs_data=0x3008 -> ras_mismatch=1 for exactly one cycle.
//   6. PC_RAS_EN, RAS_DEPTH=4: 5 jals (links L1..L5), 5 jr $ra matching L5..L2 then L1 ->
//      4 matches, 5th jr finds RAS empty -> ras_mismatch stays 0; reset mid-sequence empties RAS.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: PC register, next-PC selection, sticky jr alignment trap and retire counter.
// Optional return-address-stack checker enabled by defining PC_RAS_EN.
module pc_gen #(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter int          CNT_W     = 32,
   parameter int          RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [2:0]       pc_src,
   input  logic             zero,
   input  logic [31:0]      instr,
   input  logic [WIDTH-1:0] rs_data,
   input  logic             rs_is_ra,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             addr_err,
   output logic [CNT_W-1:0] inst_cnt,
   output logic             ras_mismatch
);

   localparam logic [WIDTH-1:0] PC_INIT = RESET_PC[WIDTH-1:0];
   localparam logic [2:0] SRC_BEQ = 3'b001;
   localparam logic [2:0] SRC_BNE = 3'b010;
   localparam logic [2:0] SRC_J   = 3'b011;
   localparam logic [2:0] SRC_JAL = 3'b100;
   localparam logic [2:0] SRC_JR  = 3'b101;

   logic [WIDTH-1:0] pc_reg;
   logic             addr_err_reg;
   logic [CNT_W-1:0] inst_cnt_reg;
   logic [WIDTH-1:0] next_pc;
   logic [WIDTH-1:0] branch_off;
   logic [WIDTH-1:0] branch_tgt;
   logic [WIDTH-1:0] jump_tgt;
   logic             is_jr;
   logic             is_jal;
   logic             upd;
   logic             trap;
   logic             unused_bits;

   assign pc       = pc_reg;
   assign addr_err = addr_err_reg;
   assign inst_cnt = inst_cnt_reg;
   assign pc_plus4 = pc_reg + WIDTH'(4);

   assign branch_off = {{(WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
   assign branch_tgt = pc_plus4 + branch_off;

   // The 256 MB region bits only exist when the PC is wider than the jump field.
   generate
      if (WIDTH == 28) begin : g_jump_narrow
         assign jump_tgt = {instr[25:0], 2'b00};
      end else begin : g_jump_wide
         assign jump_tgt = {pc_plus4[WIDTH-1:28], instr[25:0], 2'b00};
      end
   endgenerate

   assign is_jr  = (pc_src == SRC_JR);
   assign is_jal = (pc_src == SRC_JAL);
   assign upd    = !stall && !addr_err_reg;
   assign trap   = upd && is_jr && (rs_data[1:0] != 2'b00);

   always_comb begin
      next_pc = pc_plus4;
      case (pc_src)
         SRC_BEQ: next_pc = zero ? branch_tgt : pc_plus4;
         SRC_BNE: next_pc = zero ? pc_plus4 : branch_tgt;
         SRC_J,
         SRC_JAL: next_pc = jump_tgt;
         SRC_JR:  next_pc = rs_data;
         default: next_pc = pc_plus4;
      endcase
   end

   // A trapping jr neither moves the PC nor counts as a retired update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_reg       <= PC_INIT;
         addr_err_reg <= 1'b0;
         inst_cnt_reg <= '0;
      end else if (upd) begin
         if (trap) begin
            addr_err_reg <= 1'b1;
         end else begin
            pc_reg       <= next_pc;
            inst_cnt_reg <= inst_cnt_reg + CNT_W'(1);
         end
      end
   end

`ifdef PC_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] ras_ptr_reg;
   logic [PTR_W:0]   ras_cnt_reg;
   logic             ras_mismatch_reg;
   logic [PTR_W-1:0] top_idx;
   logic             push;
   logic             pop;

   assign top_idx      = ras_ptr_reg - PTR_W'(1);
   assign push         = upd && is_jal;
   assign pop          = upd && is_jr && rs_is_ra && (ras_cnt_reg != '0);
   assign ras_mismatch = ras_mismatch_reg;

   always_ff @(posedge clk) begin
      if (reset && push) begin
         ras_mem[ras_ptr_reg] <= pc_plus4;
      end
   end

   // Circular buffer: when full, the write slot is the oldest entry, so a push overwrites it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ras_ptr_reg      <= '0;
         ras_cnt_reg      <= '0;
         ras_mismatch_reg <= 1'b0;
      end else begin
         ras_mismatch_reg <= 1'b0;
         if (push) begin
            ras_ptr_reg <= ras_ptr_reg + PTR_W'(1);
            if (ras_cnt_reg != RAS_FULL) begin
               ras_cnt_reg <= ras_cnt_reg + (PTR_W+1)'(1);
            end
         end else if (pop) begin
            ras_ptr_reg      <= top_idx;
            ras_cnt_reg      <= ras_cnt_reg - (PTR_W+1)'(1);
            ras_mismatch_reg <= (ras_mem[top_idx] != rs_data);
         end
      end
   end
`else
   assign ras_mismatch = 1'b0;
`endif

   assign unused_bits = &{1'b0, instr[31:26], rs_is_ra};

endmodule
